// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data memory responder.
package mem_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'h3;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with registered read port.
module dmem_array import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    // Read register holds the last load so the result persists between loads.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency word memory on the CPU load/store port.
module data_memory_responder import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic we_q, err_q, accept, commit, bad;
    logic [AW-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    assign accept = state == IDLE && req_i;
    assign commit = state == BUSY && cnt == '0;
    // Any bit above the top word index makes the address out of range; no aliasing.
    assign bad = |(addr_i & ALIGN_MASK) || |(addr_i >> (AW + 2));
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                err_q   <= bad;
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= wdata_i;
            end
        end
    always_comb begin
        state_d = accept ? BUSY : commit ? RESP : state == RESP ? IDLE : state;
        cnt_d = accept ? CW'(LATENCY - 1) : (state == BUSY && !commit) ? cnt - 1'b1 : cnt;
    end
    assign ready_o = state == IDLE;
    assign ack_o   = state == RESP;
    assign err_o   = ack_o && err_q;
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk_i),
        .rst_n (rst_i),
        .we    (commit && we_q && !err_q),
        .re    (commit && !we_q && !err_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata_o)
    );
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Word-addressed data memory that acts as the responder on the CPU load/store port. It accepts one request at a time through a req/ready handshake and services it after a fixed, parameterised latency. It returns an ack pulse with read data and an error flag. It is the memory-side end of the port that the pipelined CPU's MEM stage will drive.

Parameters:
DEPTH, 256, number of 32-bit words; power of two; byte address range is 0 to DEPTH*4-1.
LATENCY, 3, edges from acceptance to the commit edge; must be at least 1; 0 is an elaboration-time error.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
req_i  in  1  request valid.
we_i  in  1  1 = store, 0 = load; sampled at acceptance.
addr_i  in  32  byte address; sampled at acceptance.
wdata_i  in  32  store data; sampled at acceptance.
ready_o  out  1  responder can accept a request (state IDLE).
ack_o  out  1  one-cycle completion pulse.
rdata_o  out  32  load data; valid while ack_o=1 and held until the next successful load.
err_o  out  1  request rejected; meaningful only while ack_o=1, otherwise 0.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, ready_o=1, ack_o=0, err_o=0, rdata_o=0, counter=0. Memory array is not cleared by reset; the simulation model initialises it to 0.
- FSM states: IDLE, BUSY, RESP. ready_o = (state==IDLE).
- Acceptance: a rising edge E with state IDLE and req_i=1.
  - At E: latch we_i, addr_i, wdata_i; set counter=LATENCY-1; go to BUSY.
- BUSY: counter decrements each edge. The edge where counter==0 is the commit edge, E+LATENCY:
  - a store writes the array;
  - a load captures array data into rdata_o;
  - the FSM goes to RESP.
- RESP: ack_o=1 for exactly one cycle; the next edge returns to IDLE.
  - Next acceptance is possible at E+LATENCY+2 at the earliest.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- req_i in BUSY or RESP is ignored, not queued. addr_i, wdata_i and we_i may change freely after acceptance without affecting the transaction.
- Error cases: addr[1:0]!=0 (misaligned) or addr >= DEPTH*4 (out of range).
  - The same timing applies; ack_o=1 with err_o=1.
  - No array access occurs and rdata_o is unchanged. There is no wrap-around or aliasing of high addresses.
- Store-then-load to the same address returns the stored data; ordering is strict because there is one outstanding transaction.
- Store ack: err_o=0 and rdata_o unchanged.
- Reset mid-transaction (BUSY or RESP): abort immediately with no ack. A store whose commit edge has not occurred is not performed; one already committed remains.
- Word index is addr[log2(DEPTH)+1:2].

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE, BUSY, RESP);
  - ADDR_W=32 and DATA_W=32;
  - the alignment mask constant.
- One sub-module is natural: dmem_array, a single-port synchronous RAM (DEPTH x 32) with one write-enable and a registered read port, instantiated once.
- FSM, counter and error check stay in the top block.

Test Plan:
1. Reset: hold rst_i=0 -> ready_o=1, ack_o=0, err_o=0, rdata_o=0; release with req_i=0 -> outputs unchanged.
2. LATENCY=3: store 0xDEADBEEF to 0x10 accepted at edge E -> ready_o=0 from E; ack_o=1, err_o=0 after E+3; ready_o=1 after E+4. Then load 0x10 -> ack with rdata_o=0xDEADBEEF.
3. Misaligned load 0x13 -> ack_o=1, err_o=1, rdata_o keeps 0xDEADBEEF. Misaligned store 0x11 of 0xFFFFFFFF, then load 0x10 -> still 0xDEADBEEF.
4. DEPTH=256: store 0x55AA55AA to 0x400 -> err_o=1. Load 0x0 -> 0x00000000, confirming no aliasing.
5. req_i held at 1 while addr_i changes every cycle -> accepts only at E, E+5, E+10 (LATENCY=3); each result matches the address sampled at its acceptance edge.
6. Store 0x12345678 to 0x20, rst_i=0 one cycle after acceptance -> no ack. After release, load 0x20 -> 0x00000000 with err_o=0.
